// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-select adder: segment count and operation encoding.
package csa_pkg;

    typedef enum logic {
        CSA_OP_ADD = 1'b0,
        CSA_OP_SUB = 1'b1
    } csa_op_e;

    function automatic int csa_nseg(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/csa_seg.sv
// One carry-select segment: both carry-in outcomes are computed up front, the registered
// carry from the previous stage only drives the final 2:1 mux.
module csa_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_csel,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout
);

    logic [SEG:0] w_r0;
    logic [SEG:0] w_r1;

    assign w_r0 = {1'b0, i_a} + {1'b0, i_b};
    assign w_r1 = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, 1'b1};

    assign {o_cout, o_sum} = i_csel ? w_r1 : w_r0;

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor, one segment per stage, valid/ready with global stall.
// Optional ovf/zero flags on the final stage are built when CSA_PIPE_FLAGS_EN is defined.
module csa_pipe
    import csa_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  SEG   = 8,
    localparam int NSEG  = csa_nseg(WIDTH, SEG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [NSEG-1:0]  seg_carry
`ifdef CSA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    csa_op_e w_op;
    logic    w_adv;

    assign w_op     = sub ? CSA_OP_SUB : CSA_OP_ADD;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        // Operand bits not yet consumed when entering this stage.
        localparam int RW = WIDTH - k * SEG;

        logic                  w_v_in;
        logic                  w_c_in;
        logic [RW-1:0]         w_a_in;
        logic [RW-1:0]         w_b_in;
        logic [SEG-1:0]        w_s;
        logic                  w_co;
        logic [(k+1)*SEG-1:0]  w_sum_nx;
        logic [k:0]            w_cy_nx;

        logic                  r_valid;
        logic [(k+1)*SEG-1:0]  r_sum;
        logic [k:0]            r_cy;

        if (k == 0) begin : g_first
            assign w_v_in   = in_valid;
            assign w_c_in   = (w_op == CSA_OP_SUB) ? 1'b1 : cin;
            assign w_a_in   = a;
            assign w_b_in   = (w_op == CSA_OP_SUB) ? ~b : b;
            assign w_sum_nx = w_s;
            assign w_cy_nx  = w_co;
        end else begin : g_next
            assign w_v_in   = g_stg[k-1].r_valid;
            assign w_c_in   = g_stg[k-1].r_cy[k-1];
            assign w_a_in   = g_stg[k-1].g_skew.r_a;
            assign w_b_in   = g_stg[k-1].g_skew.r_b;
            assign w_sum_nx = {w_s, g_stg[k-1].r_sum};
            assign w_cy_nx  = {w_co, g_stg[k-1].r_cy};
        end

        csa_seg #(
            .SEG(SEG)
        ) u_seg (
            .i_a    (w_a_in[SEG-1:0]),
            .i_b    (w_b_in[SEG-1:0]),
            .i_csel (w_c_in),
            .o_sum  (w_s),
            .o_cout (w_co)
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
                r_cy    <= '0;
            end else if (w_adv) begin
                r_valid <= w_v_in;
                r_sum   <= w_sum_nx;
                r_cy    <= w_cy_nx;
            end
        end

        if (k < NSEG - 1) begin : g_skew
            logic [RW-SEG-1:0] r_a;
            logic [RW-SEG-1:0] r_b;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_in[RW-1:SEG];
                    r_b <= w_b_in[RW-1:SEG];
                end
            end
        end

`ifdef CSA_PIPE_FLAGS_EN
        if (k == NSEG - 1) begin : g_flags
            logic r_ovf;
            logic r_zero;

            // w_b_in is already inverted for subtraction, so this is the B' sign bit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= (w_a_in[RW-1] == w_b_in[RW-1]) && (w_s[SEG-1] != w_a_in[RW-1]);
                    r_zero <= (w_sum_nx == '0);
                end
            end
        end
`endif
    end

    assign out_valid = g_stg[NSEG-1].r_valid;
    assign sum       = g_stg[NSEG-1].r_sum;
    assign seg_carry = g_stg[NSEG-1].r_cy;
    assign cout      = g_stg[NSEG-1].r_cy[NSEG-1];

`ifdef CSA_PIPE_FLAGS_EN
    assign ovf  = g_stg[NSEG-1].g_flags.r_ovf;
    assign zero = g_stg[NSEG-1].g_flags.r_zero;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// Self-checking bench for csa_pipe: directed add/sub cases, random streams with throttling,
// and reset while operations are in flight, against an arithmetic reference model.
module tb_csa_pipe;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [NSEG-1:0]  seg_carry;
`ifdef CSA_PIPE_FLAGS_EN
    logic             ovf;
    logic             zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_pipe #(
        .WIDTH(WIDTH),
        .SEG  (SEG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .seg_carry (seg_carry)
`ifdef CSA_PIPE_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic [NSEG-1:0]  sc;
        logic             ov;
        logic             z;
    } exp_t;

    exp_t q[$];

    // Reference: plain wide arithmetic; segment carries from masked partial sums.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c, input logic s);
        exp_t             e;
        logic [WIDTH-1:0] yb;
        logic             ce;
        logic [WIDTH:0]   t;
        logic [63:0]      mask;
        logic [63:0]      m;
        yb   = s ? ~y : y;
        ce   = s ? 1'b1 : c;
        t    = {1'b0, x} + {1'b0, yb} + {{WIDTH{1'b0}}, ce};
        e.s  = t[WIDTH-1:0];
        e.co = t[WIDTH];
        for (int k = 0; k < NSEG; k++) begin
            mask    = (64'd1 << (SEG * (k + 1))) - 64'd1;
            m       = (64'(x) & mask) + (64'(yb) & mask) + 64'(ce);
            e.sc[k] = m[SEG*(k+1)];
        end
        e.ov = (x[WIDTH-1] == yb[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
        e.z  = (e.s == '0);
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || seg_carry !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b sum=%h cout=%b seg_carry=%b, want 0/0/0/0",
                     out_valid, sum, cout, seg_carry);
        end
`ifdef CSA_PIPE_FLAGS_EN
        checks++;
        if (ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b zero=%b, want 0/0", ovf, zero);
        end
`endif
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic run_one(input string nm, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c, input logic s, input logic [WIDTH-1:0] es,
                           input logic eco, input logic [NSEG-1:0] esc, input logic eov,
                           input logic ez);
        int   lat;
        exp_t e;
        e = model(x, y, c, s);
        @(negedge clk);
        a = x; b = y; cin = c; sub = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready=%b want 1", nm, in_ready);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != NSEG) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles want %0d", nm, lat, NSEG);
        end
        checks++;
        if (sum !== es || cout !== eco || seg_carry !== esc) begin
            errors++;
            $display("FAIL %s_result: sum=%h cout=%b seg_carry=%b, want %h %b %b",
                     nm, sum, cout, seg_carry, es, eco, esc);
        end
        checks++;
        if (sum !== e.s || cout !== e.co || seg_carry !== e.sc) begin
            errors++;
            $display("FAIL %s_model: sum=%h cout=%b seg_carry=%b, want %h %b %b",
                     nm, sum, cout, seg_carry, e.s, e.co, e.sc);
        end
`ifdef CSA_PIPE_FLAGS_EN
        checks++;
        if (ovf !== eov || zero !== ez) begin
            errors++;
            $display("FAIL %s_flags: ovf=%b zero=%b, want %b %b", nm, ovf, zero, eov, ez);
        end
`else
        if (eov === 1'bx || ez === 1'bx) $display("note: %s flag expectation undefined", nm);
`endif
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_single: out_valid=%b after consume, want 0", nm, out_valid);
        end
    endtask

    task automatic test_add();
        run_one("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0100, 1'b0, 4'b0001, 1'b0, 1'b0);
        run_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0000, 1'b1, 4'b1111, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        run_one("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
                32'hFFFF_FFFE, 1'b0, 4'b0000, 1'b0, 1'b0);
        run_one("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                32'h7FFF_FFFF, 1'b1, 4'b1000, 1'b1, 1'b0);
        // cin must be ignored when subtracting.
        run_one("sub_cin", 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1,
                32'h0000_0000, 1'b1, 4'b1111, 1'b0, 1'b1);
    endtask

    task automatic stream(input string nm, input int n, input int p_in, input int p_out);
        int               sent = 0;
        int               got = 0;
        int               cyc = 0;
        int               first_in = -1;
        int               first_out = -1;
        int               last_out = -1;
        logic             hold = 1'b0;
        logic [WIDTH-1:0] hs;
        logic             hco;
        logic [NSEG-1:0]  hsc;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             c;
        logic             s;
        exp_t             e;
        q.delete();
        while (got < n && cyc < 5000) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== hs || cout !== hco || seg_carry !== hsc) begin
                    errors++;
                    $display("FAIL %s_stall_hold: valid=%b sum=%h cout=%b sc=%b, want 1 %h %b %b",
                             nm, out_valid, sum, cout, seg_carry, hs, hco, hsc);
                end
            end
            x = $urandom;
            y = $urandom;
            c = 1'($urandom_range(1));
            s = 1'($urandom_range(1));
            a = x; b = y; cin = c; sub = s;
            in_valid  = (sent < n) && ($urandom_range(99) < p_in);
            out_ready = ($urandom_range(99) < p_out);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL %s_in_ready: got %b with out_valid=%b out_ready=%b",
                         nm, in_ready, out_valid, out_ready);
            end
            if (in_valid && in_ready) begin
                q.push_back(model(x, y, c, s));
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_spurious: unexpected result sum=%h", nm, sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.co || seg_carry !== e.sc) begin
                        errors++;
                        $display("FAIL %s_result#%0d: sum=%h cout=%b sc=%b, want %h %b %b",
                                 nm, got, sum, cout, seg_carry, e.s, e.co, e.sc);
                    end
`ifdef CSA_PIPE_FLAGS_EN
                    else if (ovf !== e.ov || zero !== e.z) begin
                        errors++;
                        $display("FAIL %s_flags#%0d: ovf=%b zero=%b, want %b %b",
                                 nm, got, ovf, zero, e.ov, e.z);
                    end
`endif
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            hold = out_valid && !out_ready;
            hs   = sum;
            hco  = cout;
            hsc  = seg_carry;
            cyc++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (got != n || q.size() != 0) begin
            errors++;
            $display("FAIL %s_count: got %0d results, %0d pending, want %0d and 0",
                     nm, got, q.size(), n);
        end
        if (p_in == 100 && p_out == 100) begin
            checks++;
            if (first_out - first_in != NSEG) begin
                errors++;
                $display("FAIL %s_fill: first result after %0d cycles want %0d",
                         nm, first_out - first_in, NSEG);
            end
            checks++;
            if (last_out - first_out != n - 1) begin
                errors++;
                $display("FAIL %s_throughput: %0d results spanned %0d cycles want %0d",
                         nm, n, last_out - first_out + 1, n);
            end
        end
    endtask

    task automatic test_back_to_back();
        stream("b2b", 100, 100, 100);
    endtask

    task automatic test_throttle();
        stream("throttle", 200, 50, 50);
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: out_valid=%b after reset, want 0", out_valid);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale: out_valid=%b at cycle %0d after reset, want 0",
                         out_valid, i);
            end
        end
        run_one("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
                32'h2345_678A, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_throttle();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
